booths_divider: RTL
===================

Name: booths_divider

Overview:
- Sequential signed integer divider, the inverse of the team's sequential Booth multiplier. Uses the same load/done handshake and iterates one quotient bit per cycle.
- Computes quotient and remainder of two N-bit two's-complement operands with truncating (round-toward-zero) semantics.
- Intended to sit beside the multiplier in the arithmetic unit. Because both blocks share the handshake style, one controller can drive both.

Parameters:
- N, 32, operand/result width in bits (N >= 4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- load  input  1  start request; sampled only in IDLE.
- A  input  N  dividend, signed; captured on the edge load is sampled in IDLE.
- B  input  N  divisor, signed; captured on the same edge as A.
- done  output  1  one-cycle pulse when Q/R/div_by_zero are valid.
- Q  output  N  quotient, signed.
- R  output  N  remainder, signed.
- div_by_zero  output  1  set with done when captured B was 0.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-low on rst_n.
- Reset values: done=0, Q=0, R=0, div_by_zero=0. All internal registers clear and the state goes to IDLE. Reset mid-operation aborts the division with no done pulse.
- Registers: dividend magnitude/quotient shift register DQ[N-1:0], partial remainder PR[N:0], divisor magnitude DM[N-1:0], sign flags qneg and rneg, zero flag zf, and a down-counter cnt of $clog2(N)+1 bits.
- FSM states: IDLE, INIT, ITER, SIGN_FIX, DONE.
- IDLE:
  - done<=0.
  - If load=1: latch A and B, go to INIT.
  - Q, R and div_by_zero hold their previous result.
- INIT:
  - DQ<=|A|, DM<=|B|, PR<=0, cnt<=N.
  - qneg<=A[N-1]^B[N-1], rneg<=A[N-1], zf<=(B==0).
  - Next state is ITER.
  - |MIN| = 2^(N-1) is treated as an unsigned N-bit value.
- ITER (one restoring step per cycle):
  - t = {PR[N-1:0], DQ[N-1]} - {1'b0, DM}.
  - If t is non-negative: PR<=t, DQ<={DQ[N-2:0],1}.
  - Otherwise: PR<={PR[N-1:0],DQ[N-1]}, DQ<={DQ[N-2:0],0}.
  - cnt<=cnt-1. When cnt==1 the next state is SIGN_FIX; otherwise stay in ITER.
- SIGN_FIX:
  - If zf: quotient = all ones, remainder = original A.
  - Otherwise: quotient = qneg ? -DQ : DQ, remainder = rneg ? -PR[N-1:0] : PR[N-1:0].
  - Next state is DONE.
- DONE:
  - Q, R and div_by_zero<=zf are registered, and done<=1.
  - Next state is IDLE.
- Latency:
  - Load is sampled at edge e0. Q/R update and done rises after edge e0+N+3. Done is high for exactly one cycle.
  - The earliest next load can be sampled at edge e0+N+4.
  - Throughput is one division per N+4 cycles.
- load outside IDLE is ignored. Held load restarts a new division immediately after DONE.
- Overflow case MIN / -1: Q=MIN (2^(N-1) truncated), R=0, no flag.
- Identities for non-zero B: A == Q*B + R, |R| < |B|, and R is zero or has the sign of A.

Optional Feature:
- Macro DIV_ZERO_FAST_EN.
- Defined:
  - INIT with B==0 jumps directly to SIGN_FIX, skipping ITER.
  - For a divide-by-zero, done rises after edge e0+3.
  - Non-zero divisors are unaffected.
- Undefined:
  - Latency is fixed at N+3 for every operand pair, including B==0.
  - Divide-by-zero results are identical in both builds.

Test Plan:
- A=100, B=7 -> Q=14, R=2, div_by_zero=0. Done pulses once, 35 edges after the load edge, width 1 cycle.
- Sign combinations:
  - A=-100, B=7 -> Q=-14, R=-2.
  - A=100, B=-7 -> Q=-14, R=2.
  - A=-100, B=-7 -> Q=14, R=-2.
- Corner operands:
  - A=0x80000000, B=-1 -> Q=0x80000000, R=0.
  - A=0x80000000, B=0x80000000 -> Q=1, R=0.
  - A=5, B=9 -> Q=0, R=5.
- A=-5, B=0 -> Q=0xFFFFFFFF, R=-5 (0xFFFFFFFB), div_by_zero=1.
  - Done arrives at edge +35 without DIV_ZERO_FAST_EN, or at +3 with it.
- Pulse load=1 with new A/B during ITER -> ignored; the in-flight result is unchanged.
- Reset and load timing:
  - Assert rst_n=0 for one edge mid-ITER -> all outputs 0, state IDLE, no done pulse.
  - Hold load=1 continuously -> back-to-back results spaced N+4 cycles.
- Randomised 10k operand pairs against a reference model (truncating divide, special cases above) -> all Q/R match.

Source files
------------

// File: rtl/booths_divider.sv
`default_nettype none
// ============================================================================
// Module   : booths_divider
// Purpose  : Sequential signed restoring divider, one quotient bit per cycle,
//            truncating semantics, load/done handshake.
//            Build option DIV_ZERO_FAST_EN: divide-by-zero skips iteration.
// Revision : 1.0 - initial release
// ============================================================================
module booths_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_by_zero
);

    localparam int                C_CW        = $clog2(N) + 1;
    localparam logic [C_CW-1:0]   c_cnt_init  = C_CW'(N);
    localparam logic [C_CW-1:0]   c_cnt_last  = C_CW'(1);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_init     = 3'd1;
    localparam logic [2:0] c_st_iter     = 3'd2;
    localparam logic [2:0] c_st_sign_fix = 3'd3;
    localparam logic [2:0] c_st_done     = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;

    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_dq;
    logic [N:0]      r_pr;
    logic [N-1:0]    r_dm;
    logic            r_qneg;
    logic            r_rneg;
    logic            r_zf;
    logic [C_CW-1:0] r_cnt;
    logic [N-1:0]    r_qf;
    logic [N-1:0]    r_rf;

    logic            r_done;
    logic [N-1:0]    r_q;
    logic [N-1:0]    r_r;
    logic            r_dbz;

    logic            w_capture;
    logic            w_init;
    logic            w_iter;
    logic            w_fix;
    logic            w_finish;

    logic [N-1:0]    w_a_mag;
    logic [N-1:0]    w_b_mag;
    logic [N+1:0]    w_trial;

    // |MIN| negates to itself, which is the correct unsigned magnitude.
    assign w_a_mag = r_a[N-1] ? (~r_a + 1'b1) : r_a;
    assign w_b_mag = r_b[N-1] ? (~r_b + 1'b1) : r_b;
    // PR stays below DM, so its top bit is always 0; the extra width keeps the borrow visible.
    assign w_trial = {r_pr, r_dq[N-1]} - {2'b00, r_dm};

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:     w_next_state = load ? c_st_init : c_st_idle;
`ifdef DIV_ZERO_FAST_EN
            c_st_init:     w_next_state = (r_b == '0) ? c_st_sign_fix : c_st_iter;
`else
            c_st_init:     w_next_state = c_st_iter;
`endif
            c_st_iter:     w_next_state = (r_cnt == c_cnt_last) ? c_st_sign_fix : c_st_iter;
            c_st_sign_fix: w_next_state = c_st_done;
            c_st_done:     w_next_state = c_st_idle;
            default:       w_next_state = c_st_idle;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        w_capture = 1'b0;
        w_init    = 1'b0;
        w_iter    = 1'b0;
        w_fix     = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            c_st_idle:     w_capture = load;
            c_st_init:     w_init    = 1'b1;
            c_st_iter:     w_iter    = 1'b1;
            c_st_sign_fix: w_fix     = 1'b1;
            c_st_done:     w_finish  = 1'b1;
            default:       w_capture = 1'b0;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_dq   <= '0;
            r_pr   <= '0;
            r_dm   <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_zf   <= 1'b0;
            r_cnt  <= '0;
            r_qf   <= '0;
            r_rf   <= '0;
            r_done <= 1'b0;
            r_q    <= '0;
            r_r    <= '0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_capture) begin
                r_a <= A;
                r_b <= B;
            end
            if (w_init) begin
                r_dq   <= w_a_mag;
                r_dm   <= w_b_mag;
                r_pr   <= '0;
                r_cnt  <= c_cnt_init;
                r_qneg <= r_a[N-1] ^ r_b[N-1];
                r_rneg <= r_a[N-1];
                r_zf   <= (r_b == '0);
            end
            if (w_iter) begin
                if (!w_trial[N+1]) begin
                    r_pr <= w_trial[N:0];
                    r_dq <= {r_dq[N-2:0], 1'b1};
                end else begin
                    r_pr <= {r_pr[N-1:0], r_dq[N-1]};
                    r_dq <= {r_dq[N-2:0], 1'b0};
                end
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_fix) begin
                if (r_zf) begin
                    r_qf <= '1;
                    r_rf <= r_a;
                end else begin
                    r_qf <= r_qneg ? (~r_dq + 1'b1) : r_dq;
                    r_rf <= r_rneg ? (~r_pr[N-1:0] + 1'b1) : r_pr[N-1:0];
                end
            end
            if (w_finish) begin
                r_q   <= r_qf;
                r_r   <= r_rf;
                r_dbz <= r_zf;
            end
        end
    end

    assign done        = r_done;
    assign Q           = r_q;
    assign R           = r_r;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
